fetch_stage: RTL

//  Instruction-fetch stage of the 5-stage pipelined MIPS core, directly upstream of decode.

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/fetch_stage_if.sv | 27 ++
 rtl/reg_fetch_to_decode.sv | 46 ++++
 rtl/fetch_stage.sv | 129 ++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the fetch stage: datapath widths, NOP encoding, fetch FSM states
// and the jump-target helper.
`default_nettype none

package pipe_pkg;

  localparam int XLEN   = 32;
  localparam int JIDX_W = 28;

  localparam logic [XLEN-1:0] NOP_DEFAULT = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [XLEN-1:0] PC_STEP     = 32'd4;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    PEND  = 1'b1
  } fetch_state_t;

  // J-type target keeps the upper nibble of the delay-slot PC.
  function automatic logic [XLEN-1:0] jump_target(input logic [XLEN-1:0]   pcplus4,
                                                  input logic [JIDX_W-1:0] shifted);
    return {pcplus4[XLEN-1:JIDX_W], shifted};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage (master) and imem (slave).
`default_nettype none

interface fetch_stage_if;

  logic                     imem_req;
  logic [pipe_pkg::XLEN-1:0] imem_addr;
  logic                     imem_ack;
  logic [pipe_pkg::XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

`default_nettype wire

// File: rtl/reg_fetch_to_decode.sv
// Fetch->Decode pipeline register: clear beats enable; an enabled cycle without a
// fetched word inserts a bubble.
`default_nettype none

module reg_fetch_to_decode
  import pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            en,
  input  logic            load,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] pcplus4_in,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] pcplus4_out,
  output logic            valid_out
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_out   <= NOP_INSTR;
      pcplus4_out <= '0;
      valid_out   <= 1'b0;
    end else if (clr) begin
      instr_out   <= NOP_INSTR;
      pcplus4_out <= '0;
      valid_out   <= 1'b0;
    end else if (en) begin
      if (load) begin
        instr_out   <= instr_in;
        pcplus4_out <= pcplus4_in;
        valid_out   <= 1'b1;
      end else begin
        instr_out   <= NOP_INSTR;
        pcplus4_out <= '0;
        valid_out   <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, next-PC selection, multi-cycle imem handshake with
// redirect capture, and the Fetch->Decode register. Optional counters under FETCH_PERF_EN.
`default_nettype none

module fetch_stage
  import pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stallF,
  input  logic              stallD,
  input  logic              flushD,
  input  logic              pcsrcD,
  input  logic [XLEN-1:0]   pcbranchD,
  input  logic              jumpD,
  input  logic [JIDX_W-1:0] instrDshifted,
  fetch_stage_if.master     imem,
  output logic [XLEN-1:0]   instrD,
  output logic [XLEN-1:0]   pcplus4D,
  output logic              validD,
  output logic              fetch_wait,
  output logic [XLEN-1:0]   pcF
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_waitcyc
`endif
);

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] pc_q, pc_nxt;
  logic [XLEN-1:0] pend_target, pend_target_nxt;
  logic [XLEN-1:0] pcplus4F;
  logic [XLEN-1:0] redirect_target;
  logic            req_q;
  logic            ack;
  logic            redirect;
  logic            load_fd;

  assign pcplus4F        = pc_q + PC_STEP;
  assign redirect        = jumpD | pcsrcD;
  assign redirect_target = jumpD ? jump_target(pcplus4D, instrDshifted) : pcbranchD;

  // An ack is only meaningful while a request is actually being presented.
  assign ack        = req_q & imem.imem_ack;
  assign load_fd    = ack & (state == FETCH);
  assign fetch_wait = req_q & ~imem.imem_ack;

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign pcF            = pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q       <= 1'b0;
      state       <= FETCH;
      pc_q        <= RESET_PC;
      pend_target <= '0;
    end else begin
      req_q       <= 1'b1;
      state       <= state_nxt;
      pc_q        <= pc_nxt;
      pend_target <= pend_target_nxt;
    end
  end

  // A redirect seen while imem is busy is parked; the in-flight word is then dropped.
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc_q;
    pend_target_nxt = pend_target;
    case (state)
      FETCH: begin
        if (ack) begin
          if (!stallF) begin
            pc_nxt = redirect ? redirect_target : pcplus4F;
          end
        end else if (redirect) begin
          pend_target_nxt = redirect_target;
          state_nxt       = PEND;
        end
      end
      PEND: begin
        if (ack) begin
          pc_nxt    = pend_target;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  reg_fetch_to_decode #(
    .NOP_INSTR (NOP_INSTR)
  ) u_reg_fd (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (flushD),
    .en          (~stallD),
    .load        (load_fd),
    .instr_in    (imem.imem_rdata),
    .pcplus4_in  (pcplus4F),
    .instr_out   (instrD),
    .pcplus4_out (pcplus4D),
    .valid_out   (validD)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_waitcyc <= '0;
    end else begin
      if (!flushD && !stallD && load_fd) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (fetch_wait) begin
        perf_waitcyc <= perf_waitcyc + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire
